vram_rd_arb: RTL and testbench

//  Two-requester arbiter for the single AXI read port (HP) feeding VRAM reads.
//  M0 = display read controller (real-time, high priority); M1 = secondary reader (drawing/capture).

---
 rtl/disp_axi_pkg.sv | 21 ++
 rtl/vram_arb_sel.sv | 48 ++++
 rtl/vram_rd_arb.sv | 117 +++++++++++
 tb/tb_vram_rd_arb.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_axi_pkg.sv
// Shared definitions for the display AXI read path.
//  - ARB_* : read-arbiter state encodings
//  - AXI_ADDR_W / AXI_LEN_W : AR channel field widths
//  - ar_req_t : one AR request (address + burst length-1)
package disp_axi_pkg;

   localparam int AXI_ADDR_W = 32;
   localparam int AXI_LEN_W  = 8;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'b00,
      ARB_ADDR = 2'b01,
      ARB_DATA = 2'b10
   } arb_state_e;

   typedef struct packed {
      logic [AXI_ADDR_W-1:0] addr;
      logic [AXI_LEN_W-1:0]  len;
   } ar_req_t;

endpackage

// File: rtl/vram_arb_sel.sv
// Priority select for the VRAM read arbiter, with the M1 anti-starvation counter.
// Ports:
//  ACLK, ARESETN : clock, async active-low reset
//  arb_en        : arbiter is idle with a request pending; grant is taken this edge
//  req0, req1    : M0 / M1 ARVALID
//  gnt_nxt       : one-hot {M1,M0} grant to register this edge (00 if no request)
module vram_arb_sel
   import disp_axi_pkg::*;
#(
   parameter int MAX_CONSEC = 4
)(
   input  logic       ACLK,
   input  logic       ARESETN,
   input  logic       arb_en,
   input  logic       req0,
   input  logic       req1,
   output logic [1:0] gnt_nxt
);

   localparam int CNT_W = $clog2(MAX_CONSEC + 1);

   logic [CNT_W-1:0] cnt;
   logic             cnt_full;

   assign cnt_full = (cnt == CNT_W'(MAX_CONSEC));

   // M0 wins ties until it has taken MAX_CONSEC grants in a row while M1 waited.
   always_comb begin
      gnt_nxt = 2'b00;
      if (req1 && (!req0 || cnt_full))
         gnt_nxt = 2'b10;
      else if (req0)
         gnt_nxt = 2'b01;
   end

   // Only M0 grants that actually made M1 wait count; anything else clears the run.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)
         cnt <= '0;
      else if (arb_en) begin
         if (gnt_nxt[0] && req1)
            cnt <= cnt_full ? cnt : cnt + 1'b1;
         else
            cnt <= '0;
      end
   end

endmodule

// File: rtl/vram_rd_arb.sv
// Two-requester arbiter for the single AXI HP read port feeding VRAM reads.
// M0 = display read controller (high priority), M1 = secondary reader.
// One whole burst (AR handshake through RLAST) per grant, one outstanding burst.
// Ports:
//  ACLK, ARESETN        : clock, async active-low reset
//  M0_* / M1_*          : requester AR and R channels (RDATA/RLAST broadcast,
//                         RVALID/ARREADY only to the granted requester)
//  S_*                  : AR and R channels toward the PS slave port
//  GRANT                : one-hot owner {M1,M0}, 00 when idle
module vram_rd_arb
   import disp_axi_pkg::*;
#(
   parameter int DATA_W     = 64,
   parameter int MAX_CONSEC = 4
)(
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic [AXI_ADDR_W-1:0] M0_ARADDR,
   input  logic [AXI_LEN_W-1:0]  M0_ARLEN,
   input  logic                  M0_ARVALID,
   output logic                  M0_ARREADY,
   output logic [DATA_W-1:0]     M0_RDATA,
   output logic                  M0_RLAST,
   output logic                  M0_RVALID,
   input  logic                  M0_RREADY,
   input  logic [AXI_ADDR_W-1:0] M1_ARADDR,
   input  logic [AXI_LEN_W-1:0]  M1_ARLEN,
   input  logic                  M1_ARVALID,
   output logic                  M1_ARREADY,
   output logic [DATA_W-1:0]     M1_RDATA,
   output logic                  M1_RLAST,
   output logic                  M1_RVALID,
   input  logic                  M1_RREADY,
   output logic [AXI_ADDR_W-1:0] S_ARADDR,
   output logic [AXI_LEN_W-1:0]  S_ARLEN,
   output logic                  S_ARVALID,
   input  logic                  S_ARREADY,
   input  logic [DATA_W-1:0]     S_RDATA,
   input  logic                  S_RLAST,
   input  logic                  S_RVALID,
   output logic                  S_RREADY,
   output logic [1:0]            GRANT
);

   arb_state_e st;
   logic [1:0] grant_q;
   logic [1:0] gnt_nxt;
   logic       arb_en;
   logic       in_addr;
   logic       in_data;
   ar_req_t    ar_sel;

   assign arb_en = (st == ARB_IDLE) && (M0_ARVALID || M1_ARVALID);

   vram_arb_sel #(
      .MAX_CONSEC (MAX_CONSEC)
   ) u_sel (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .arb_en  (arb_en),
      .req0    (M0_ARVALID),
      .req1    (M1_ARVALID),
      .gnt_nxt (gnt_nxt)
   );

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         st      <= ARB_IDLE;
         grant_q <= 2'b00;
      end else begin
         case (st)
            ARB_IDLE:
               if (arb_en) begin
                  grant_q <= gnt_nxt;
                  st      <= ARB_ADDR;
               end
            ARB_ADDR:
               if (S_ARREADY)
                  st <= ARB_DATA;
            ARB_DATA:
               if (S_RVALID && S_RREADY && S_RLAST) begin
                  grant_q <= 2'b00;
                  st      <= ARB_IDLE;
               end
            default: begin
               grant_q <= 2'b00;
               st      <= ARB_IDLE;
            end
         endcase
      end
   end

   // Valid gating comes from registered state only; ready paths pass straight through.
   assign in_addr = (st == ARB_ADDR);
   assign in_data = (st == ARB_DATA);

   // Requester holds its AR fields until ARREADY, so the mux output stays stable.
   assign ar_sel    = grant_q[1] ? {M1_ARADDR, M1_ARLEN} : {M0_ARADDR, M0_ARLEN};
   assign S_ARVALID = in_addr;
   assign S_ARADDR  = ar_sel.addr;
   assign S_ARLEN   = ar_sel.len;

   assign M0_ARREADY = in_addr && grant_q[0] && S_ARREADY;
   assign M1_ARREADY = in_addr && grant_q[1] && S_ARREADY;

   assign S_RREADY  = in_data && ((grant_q[0] && M0_RREADY) || (grant_q[1] && M1_RREADY));
   assign M0_RVALID = in_data && grant_q[0] && S_RVALID;
   assign M1_RVALID = in_data && grant_q[1] && S_RVALID;

   assign M0_RDATA = S_RDATA;
   assign M1_RDATA = S_RDATA;
   assign M0_RLAST = S_RLAST;
   assign M1_RLAST = S_RLAST;

   assign GRANT = grant_q;

endmodule

// File: tb/tb_vram_rd_arb.sv
module tb_vram_rd_arb;

   localparam int DATA_W     = 64;
   localparam int MAX_CONSEC = 4;

   logic              ACLK    = 1'b0;
   logic              ARESETN = 1'b0;
   logic [31:0]       M0_ARADDR, M1_ARADDR, S_ARADDR;
   logic [7:0]        M0_ARLEN, M1_ARLEN, S_ARLEN;
   logic              M0_ARVALID, M1_ARVALID, M0_ARREADY, M1_ARREADY;
   logic [DATA_W-1:0] M0_RDATA, M1_RDATA, S_RDATA;
   logic              M0_RLAST, M1_RLAST, S_RLAST;
   logic              M0_RVALID, M1_RVALID, M0_RREADY, M1_RREADY;
   logic              S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;
   logic [1:0]        GRANT;

   vram_rd_arb #(.DATA_W(DATA_W), .MAX_CONSEC(MAX_CONSEC)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
      .M0_RDATA(M0_RDATA), .M0_RLAST(M0_RLAST), .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
      .M1_ARADDR(M1_ARADDR), .M1_ARLEN(M1_ARLEN), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
      .M1_RDATA(M1_RDATA), .M1_RLAST(M1_RLAST), .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
      .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
      .S_RDATA(S_RDATA), .S_RLAST(S_RLAST), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
      .GRANT(GRANT)
   );

   always #5 ACLK = ~ACLK;

   int n_chk = 0, n_pass = 0;

   // slave / monitor state
   int          ar_pct = 100, r_pct = 100, ar_stall = 0;
   bit          rr_rand0 = 0, rr_rand1 = 0;
   bit          sl_busy = 0, rd_consumed = 0, arv_prev = 0;
   logic [31:0] sl_addr = '0;
   logic [7:0]  sl_len = '0, sl_beat = '0;
   logic [39:0] arv_hold = '0;
   int          arv_cnt = 0, stab_err = 0, proto_err = 0, rv_seen0 = 0, rv_seen1 = 0;
   logic [64:0] rx0[$], rx1[$], exp0[$], exp1[$];
   logic [1:0]  glog[$], exp_g[$];
   // reference arbitration model
   bit          mdl_busy = 0;
   int          mdl_run = 0;

   function automatic logic [64:0] beat_w(input logic [31:0] a, input int b, input bit last);
      return {last, a, 24'h0, 8'(b)};
   endfunction

   // Slave port model + monitor: samples on negedge, drives 1 time unit after posedge.
   task automatic env_loop();
      forever begin
         @(negedge ACLK);
         rd_consumed = 1'b0;
         if (!ARESETN) begin
            sl_busy = 0; arv_prev = 0; mdl_busy = 0; mdl_run = 0;
         end else begin
            if (S_ARVALID) begin
               arv_cnt++;
               if (arv_prev && ({S_ARADDR, S_ARLEN} != arv_hold)) stab_err++;
            end else if (arv_prev) stab_err++;
            arv_prev = S_ARVALID && !S_ARREADY;
            arv_hold = {S_ARADDR, S_ARLEN};
            if (S_ARVALID && S_ARREADY) begin
               glog.push_back(GRANT);
               sl_busy = 1; sl_addr = S_ARADDR; sl_len = S_ARLEN; sl_beat = 0;
            end
            if (M0_RVALID) rv_seen0++;
            if (M1_RVALID) rv_seen1++;
            if (S_RVALID && S_RREADY) begin
               rd_consumed = 1'b1;
               if (M0_RVALID && M0_RREADY && !M1_RVALID) rx0.push_back({M0_RLAST, M0_RDATA});
               else if (M1_RVALID && M1_RREADY && !M0_RVALID) rx1.push_back({M1_RLAST, M1_RDATA});
               else proto_err++;
            end
            // M1 is owed a grant once M0 has won MAX_CONSEC times in a row over it.
            if (!mdl_busy && (M0_ARVALID || M1_ARVALID)) begin
               if (M1_ARVALID && (!M0_ARVALID || mdl_run == MAX_CONSEC)) begin
                  exp_g.push_back(2'b10); mdl_run = 0;
               end else begin
                  exp_g.push_back(2'b01);
                  mdl_run = M1_ARVALID ? ((mdl_run < MAX_CONSEC) ? mdl_run + 1 : mdl_run) : 0;
               end
               mdl_busy = 1;
            end
            if (rd_consumed) begin
               if (sl_beat == sl_len) begin sl_busy = 0; mdl_busy = 0; end
               else sl_beat++;
            end
         end
         @(posedge ACLK); #1;
         if (!ARESETN) begin
            S_ARREADY = 0; S_RVALID = 0; S_RLAST = 0;
         end else begin
            if (ar_stall > 0) begin S_ARREADY = 0; ar_stall--; end
            else S_ARREADY = (int'($urandom_range(99)) < ar_pct);
            if (!S_RVALID || rd_consumed) begin
               if (sl_busy && (int'($urandom_range(99)) < r_pct)) begin
                  S_RVALID = 1; S_RDATA = {sl_addr, 24'h0, sl_beat}; S_RLAST = (sl_beat == sl_len);
               end else begin
                  S_RVALID = 0; S_RLAST = 0;
               end
            end
         end
         M0_RREADY = rr_rand0 ? ($urandom_range(1) == 1) : 1'b1;
         M1_RREADY = rr_rand1 ? ($urandom_range(1) == 1) : 1'b1;
      end
   endtask

   // Requester AR issue; caller is at posedge+1. Returns at posedge+1 after the handshake.
   task automatic m_issue(input int m, input logic [31:0] a, input logic [7:0] l, output bit ok);
      ok = 0;
      if (m == 0) begin M0_ARADDR = a; M0_ARLEN = l; M0_ARVALID = 1; end
      else        begin M1_ARADDR = a; M1_ARLEN = l; M1_ARVALID = 1; end
      for (int t = 0; t < 2000 && !ok; t++) begin
         @(negedge ACLK);
         ok = (m == 0) ? M0_ARREADY : M1_ARREADY;
      end
      @(posedge ACLK); #1;
      if (m == 0) M0_ARVALID = 0; else M1_ARVALID = 0;
   endtask

   task automatic test_reset();
      bit ok;
      ARESETN = 0;
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      n_chk++; if ({S_ARVALID, S_RREADY, M0_ARREADY, M1_ARREADY, M0_RVALID, M1_RVALID} !== 6'b0)
         $display("FAIL reset_outs: got %b want 000000", {S_ARVALID, S_RREADY, M0_ARREADY, M1_ARREADY, M0_RVALID, M1_RVALID});
      else n_pass++;
      n_chk++; if (GRANT !== 2'b00) $display("FAIL reset_grant: got %b want 00", GRANT); else n_pass++;
      ARESETN = 1;
      @(negedge ACLK);
      n_chk++; if ({GRANT, S_ARVALID} !== 3'b000) $display("FAIL reset_idle: got %b want 000", {GRANT, S_ARVALID}); else n_pass++;
      // reset in the middle of a burst
      rx0.delete();
      @(posedge ACLK); #1;
      m_issue(0, 32'h2000_0000, 8'd15, ok);
      for (int t = 0; t < 200 && rx0.size() < 4; t++) @(negedge ACLK);
      n_chk++; if (!(ok && rx0.size() >= 4)) $display("FAIL reset_midburst_setup: beats %0d want >=4", rx0.size()); else n_pass++;
      @(posedge ACLK); #3;
      ARESETN = 0;
      #1;
      n_chk++; if ({S_ARVALID, S_RREADY, M0_ARREADY, M1_ARREADY, M0_RVALID, M1_RVALID} !== 6'b0)
         $display("FAIL reset_async_outs: got %b want 000000", {S_ARVALID, S_RREADY, M0_ARREADY, M1_ARREADY, M0_RVALID, M1_RVALID});
      else n_pass++;
      n_chk++; if (GRANT !== 2'b00) $display("FAIL reset_async_grant: got %b want 00", GRANT); else n_pass++;
      repeat (2) @(posedge ACLK);
      @(negedge ACLK); ARESETN = 1;
      @(negedge ACLK);
      n_chk++; if ({GRANT, S_ARVALID, S_RREADY} !== 4'b0000) $display("FAIL reset_release_idle: got %b want 0000", {GRANT, S_ARVALID, S_RREADY}); else n_pass++;
   endtask

   task automatic test_m0_only();
      rx0.delete(); rx1.delete(); rv_seen1 = 0; proto_err = 0;
      @(posedge ACLK); #1;
      M0_ARADDR = 32'h1000_0000; M0_ARLEN = 8'd15; M0_ARVALID = 1;
      @(negedge ACLK);
      n_chk++; if (S_ARVALID !== 1'b0) $display("FAIL m0_arvalid_early: got %b want 0", S_ARVALID); else n_pass++;
      @(negedge ACLK);
      n_chk++; if ({S_ARVALID, GRANT, M0_ARREADY, M1_ARREADY} !== 5'b10110) $display("FAIL m0_addr_phase: got %b want 10110", {S_ARVALID, GRANT, M0_ARREADY, M1_ARREADY}); else n_pass++;
      n_chk++; if ({S_ARADDR, S_ARLEN} !== {32'h1000_0000, 8'd15}) $display("FAIL m0_ar_fields: got %h want 100000000f", {S_ARADDR, S_ARLEN}); else n_pass++;
      @(posedge ACLK); #1; M0_ARVALID = 0;
      for (int t = 0; t < 400 && rx0.size() < 16; t++) @(negedge ACLK);
      n_chk++; if (rx0.size() != 16) $display("FAIL m0_beat_count: got %0d want 16", rx0.size()); else n_pass++;
      for (int i = 0; i < rx0.size() && i < 16; i++) begin
         n_chk++; if (rx0[i] !== beat_w(32'h1000_0000, i, i == 15)) $display("FAIL m0_beat%0d: got %h want %h", i, rx0[i], beat_w(32'h1000_0000, i, i == 15)); else n_pass++;
      end
      @(negedge ACLK);
      n_chk++; if (GRANT !== 2'b00) $display("FAIL m0_grant_after: got %b want 00", GRANT); else n_pass++;
      n_chk++; if ({rv_seen1, rx1.size(), proto_err} != 0) $display("FAIL m0_m1_quiet: rvalid %0d beats %0d perr %0d want 0", rv_seen1, rx1.size(), proto_err); else n_pass++;
   endtask

   task automatic test_m1_single();
      logic [31:0] a;
      a = $urandom;
      rx0.delete(); rx1.delete(); rv_seen1 = 0;
      @(posedge ACLK); #1;
      M1_ARADDR = a; M1_ARLEN = 8'd0; M1_ARVALID = 1;
      @(negedge ACLK); @(negedge ACLK);
      n_chk++; if ({S_ARVALID, GRANT, M1_ARREADY, S_ARADDR} !== {1'b1, 2'b10, 1'b1, a}) $display("FAIL m1_addr_phase: got %b %b %b %h", S_ARVALID, GRANT, M1_ARREADY, S_ARADDR); else n_pass++;
      @(posedge ACLK); #1; M1_ARVALID = 0;
      for (int t = 0; t < 100 && rx1.size() < 1; t++) @(negedge ACLK);
      n_chk++; if (rx1.size() != 1) $display("FAIL m1_beat_count: got %0d want 1", rx1.size());
      else if (rx1[0] !== beat_w(a, 0, 1)) $display("FAIL m1_beat: got %h want %h", rx1[0], beat_w(a, 0, 1));
      else n_pass++;
      n_chk++; if (rv_seen1 == 0 || rx0.size() != 0) $display("FAIL m1_rvalid_route: m1 rvalid %0d m0 beats %0d", rv_seen1, rx0.size()); else n_pass++;
      @(negedge ACLK);
      n_chk++; if (GRANT !== 2'b00) $display("FAIL m1_grant_after: got %b want 00", GRANT); else n_pass++;
   endtask

   task automatic test_fairness();
      logic [1:0] pat [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
      int to0, to1;
      to0 = 0; to1 = 0;
      glog.delete(); rx0.delete(); rx1.delete();
      ar_pct = 80; r_pct = 70; rr_rand0 = 1; rr_rand1 = 1;
      @(posedge ACLK); #1;
      fork
         begin
            bit ok;
            for (int i = 0; i < 8; i++) begin m_issue(0, 32'h3000_0000 + 32'(i) * 32'h100, 8'd1, ok); if (!ok) to0++; end
         end
         begin
            bit ok;
            for (int i = 0; i < 2; i++) begin m_issue(1, 32'h4000_0000 + 32'(i) * 32'h100, 8'd1, ok); if (!ok) to1++; end
         end
      join
      for (int t = 0; t < 1000 && (rx0.size() < 16 || rx1.size() < 4); t++) @(negedge ACLK);
      n_chk++; if (to0 + to1 != 0 || rx0.size() != 16 || rx1.size() != 4)
         $display("FAIL fair_drain: timeouts %0d beats %0d/%0d want 0 16/4", to0 + to1, rx0.size(), rx1.size());
      else n_pass++;
      n_chk++; if (glog.size() != 10) $display("FAIL fair_grants: got %0d want 10", glog.size()); else n_pass++;
      for (int i = 0; i < 10 && i < glog.size(); i++) begin
         n_chk++; if (glog[i] !== pat[i]) $display("FAIL fair_order%0d: got %b want %b", i, glog[i], pat[i]); else n_pass++;
      end
   endtask

   task automatic test_stall();
      logic [31:0] a;
      bit ok;
      a = $urandom;
      rx0.delete(); ar_pct = 100; r_pct = 50; rr_rand0 = 1; rr_rand1 = 0;
      @(negedge ACLK);
      ar_stall = 6; arv_cnt = 0; stab_err = 0;
      @(posedge ACLK); #1;
      m_issue(0, a, 8'd7, ok);
      for (int t = 0; t < 500 && rx0.size() < 8; t++) @(negedge ACLK);
      n_chk++; if (!ok || arv_cnt != 6) $display("FAIL stall_arvalid_cycles: got %0d want 6", arv_cnt); else n_pass++;
      n_chk++; if (stab_err != 0) $display("FAIL stall_ar_stable: got %0d changes want 0", stab_err); else n_pass++;
      n_chk++; if (rx0.size() != 8) $display("FAIL stall_beat_count: got %0d want 8", rx0.size()); else n_pass++;
      for (int i = 0; i < rx0.size() && i < 8; i++) begin
         n_chk++; if (rx0[i] !== beat_w(a, i, i == 7)) $display("FAIL stall_beat%0d: got %h want %h", i, rx0[i], beat_w(a, i, i == 7)); else n_pass++;
      end
      @(negedge ACLK);
   endtask

   task automatic test_back_to_back();
      logic [31:0] a0, a1;
      bit ok, seen;
      a0 = $urandom; a1 = $urandom; seen = 0;
      rx1.delete(); ar_pct = 100; r_pct = 100; rr_rand0 = 0; rr_rand1 = 0;
      @(posedge ACLK); #1;
      m_issue(0, a0, 8'd3, ok);
      for (int t = 0; t < 100; t++) begin
         @(negedge ACLK);
         if (M0_RVALID && M0_RREADY && M0_RLAST) begin seen = 1; break; end
      end
      n_chk++; if (!(ok && seen)) $display("FAIL b2b_m0_last: got %0d want 1", seen); else n_pass++;
      M1_ARADDR = a1; M1_ARLEN = 8'd2; M1_ARVALID = 1;
      @(negedge ACLK);
      n_chk++; if ({S_ARVALID, GRANT} !== 3'b000) $display("FAIL b2b_dead_cycle: got %b want 000", {S_ARVALID, GRANT}); else n_pass++;
      @(negedge ACLK);
      n_chk++; if ({S_ARVALID, GRANT, S_ARADDR} !== {3'b110, a1}) $display("FAIL b2b_m1_addr: got %b %h want 110 %h", {S_ARVALID, GRANT}, S_ARADDR, a1); else n_pass++;
      @(posedge ACLK); #1; M1_ARVALID = 0;
      for (int t = 0; t < 100 && rx1.size() < 3; t++) @(negedge ACLK);
      n_chk++; if (rx1.size() != 3) $display("FAIL b2b_m1_beats: got %0d want 3", rx1.size());
      else if (rx1[2] !== beat_w(a1, 2, 1)) $display("FAIL b2b_m1_last: got %h want %h", rx1[2], beat_w(a1, 2, 1));
      else n_pass++;
      @(negedge ACLK);
   endtask

   task automatic master_run(input int m, input int n, output int to);
      bit ok;
      logic [31:0] a;
      logic [7:0] l;
      int g;
      to = 0;
      for (int i = 0; i < n; i++) begin
         g = $urandom_range(0, 5);
         if (g > 0) begin repeat (g) @(posedge ACLK); #1; end
         a = $urandom; l = 8'($urandom_range(0, 7));
         for (int b = 0; b <= int'(l); b++) begin
            if (m == 0) exp0.push_back(beat_w(a, b, b == int'(l)));
            else        exp1.push_back(beat_w(a, b, b == int'(l)));
         end
         m_issue(m, a, l, ok);
         if (!ok) to++;
      end
   endtask

   task automatic test_random();
      int to0, to1;
      glog.delete(); exp_g.delete(); rx0.delete(); rx1.delete(); exp0.delete(); exp1.delete();
      ar_pct = 60; r_pct = 60; rr_rand0 = 1; rr_rand1 = 1; stab_err = 0; proto_err = 0;
      @(posedge ACLK); #1;
      fork
         master_run(0, 15, to0);
         master_run(1, 15, to1);
      join
      for (int t = 0; t < 5000 && (rx0.size() < exp0.size() || rx1.size() < exp1.size()); t++) @(negedge ACLK);
      n_chk++; if (to0 + to1 != 0) $display("FAIL rand_timeouts: got %0d want 0", to0 + to1); else n_pass++;
      n_chk++; if (glog.size() != exp_g.size()) $display("FAIL rand_grant_count: got %0d want %0d", glog.size(), exp_g.size()); else n_pass++;
      for (int i = 0; i < glog.size() && i < exp_g.size(); i++) begin
         n_chk++; if (glog[i] !== exp_g[i]) $display("FAIL rand_grant%0d: got %b want %b", i, glog[i], exp_g[i]); else n_pass++;
      end
      n_chk++; if (rx0.size() != exp0.size() || rx1.size() != exp1.size())
         $display("FAIL rand_beat_count: got %0d/%0d want %0d/%0d", rx0.size(), rx1.size(), exp0.size(), exp1.size());
      else n_pass++;
      for (int i = 0; i < rx0.size() && i < exp0.size(); i++) begin
         n_chk++; if (rx0[i] !== exp0[i]) $display("FAIL rand_m0_beat%0d: got %h want %h", i, rx0[i], exp0[i]); else n_pass++;
      end
      for (int i = 0; i < rx1.size() && i < exp1.size(); i++) begin
         n_chk++; if (rx1[i] !== exp1[i]) $display("FAIL rand_m1_beat%0d: got %h want %h", i, rx1[i], exp1[i]); else n_pass++;
      end
      n_chk++; if (proto_err != 0 || stab_err != 0) $display("FAIL rand_protocol: routing %0d ar_change %0d want 0 0", proto_err, stab_err); else n_pass++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      M0_ARADDR = '0; M0_ARLEN = '0; M0_ARVALID = 0; M0_RREADY = 0;
      M1_ARADDR = '0; M1_ARLEN = '0; M1_ARVALID = 0; M1_RREADY = 0;
      S_ARREADY = 0; S_RDATA = '0; S_RLAST = 0; S_RVALID = 0;
      fork env_loop(); join_none
      test_reset();
      test_m0_only();
      test_m1_single();
      test_fairness();
      test_stall();
      test_back_to_back();
      test_random();
      repeat (3) @(posedge ACLK);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
